// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the cordic_sched scheduler slice.
// Optional feature macro used by this slice: CORDIC_SCHED_OPCOUNT_EN.
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    localparam int OPCOUNT_WIDTH = 32;

    // Saturating increment so a long-running counter pins at all-ones instead of wrapping.
    function automatic logic [OPCOUNT_WIDTH-1:0] sat_inc(input logic [OPCOUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module cordic_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                enable,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic [ID_WIDTH-1:0] idx_s;
    logic                found_s;
    logic                hit_s;

    // ptr + off stays below 2*NUM_REQ, so a single conditional subtract wraps it.
    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        s = (s >= NUM_REQ) ? s - NUM_REQ : s;
        return s[ID_WIDTH-1:0];
    endfunction

    // Scan requesters in rotated order and keep only the first hit.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s        = wrap_idx(ptr, i);
            hit_s        = enable & ~found_s & req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_id     = hit_s ? idx_s : grant_id;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler/sequencer for one shared cordic_data datapath.
// Define CORDIC_SCHED_OPCOUNT_EN to add the saturating op_count output.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_target,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         load_regs,
    output logic                         add,
    output logic                         sub,
    output logic                         iter,
    output logic [BIT_WIDTH-1:0]         target_out,
    input  logic [BIT_WIDTH-1:0]         dp_x,
    input  logic [BIT_WIDTH-1:0]         dp_y,
    input  logic                         reached_target,
    input  logic                         dir,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BIT_WIDTH-1:0]         out_x,
    output logic [BIT_WIDTH-1:0]         out_y,
    output logic [ID_WIDTH-1:0]          out_id
`ifdef CORDIC_SCHED_OPCOUNT_EN
    ,
    output logic [OPCOUNT_WIDTH-1:0]     op_count
`endif
);

    sched_state_t        state_r, state_nxt_s;
    logic [ID_WIDTH-1:0] ptr_r, id_r, grant_id_s;
    logic [BIT_WIDTH-1:0] tgt_r, out_x_r, out_y_r;
    logic                out_valid_r;
    logic [NUM_REQ-1:0]  grant_s;
    logic                arb_en_s, take_s, done_hs_s, capture_s;
    logic                load_s, add_s, sub_s, iter_s;

    cordic_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_r),
        .enable   (arb_en_s),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    assign arb_en_s   = (state_r == IDLE);
    assign take_s     = |(req_valid & grant_s);
    assign done_hs_s  = out_valid_r & out_ready;

    assign req_ready  = grant_s;
    assign load_regs  = load_s;
    assign add        = add_s;
    assign sub        = sub_s;
    assign iter       = iter_s;
    assign target_out = tgt_r;
    assign out_valid  = out_valid_r;
    assign out_x      = out_x_r;
    assign out_y      = out_y_r;
    assign out_id     = id_r;

    // Next-state and datapath strobes; add/sub follow dir in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        add_s       = 1'b0;
        sub_s       = 1'b0;
        iter_s      = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (take_s) state_nxt_s = LOAD;
                else        state_nxt_s = IDLE;
            end
            LOAD: begin
                load_s      = 1'b1;
                state_nxt_s = ROTATE;
            end
            ROTATE: begin
                if (reached_target) begin
                    capture_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    add_s  = dir;
                    sub_s  = ~dir;
                    iter_s = 1'b1;
                end
            end
            DONE: begin
                if (done_hs_s) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, grant bookkeeping and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            id_r        <= '0;
            tgt_r       <= '0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                tgt_r <= req_target[int'(grant_id_s)*BIT_WIDTH +: BIT_WIDTH];
                id_r  <= grant_id_s;
                ptr_r <= (grant_id_s == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id_s + ID_WIDTH'(1);
            end
            if (capture_s) begin
                out_x_r     <= dp_x;
                out_y_r     <= dp_y;
                out_valid_r <= 1'b1;
            end else if (done_hs_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef CORDIC_SCHED_OPCOUNT_EN
    logic [OPCOUNT_WIDTH-1:0] op_count_r;

    // Completed-operation counter, advanced on each accepted result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          op_count_r <= '0;
        else if (done_hs_s) op_count_r <= sat_inc(op_count_r);
    end

    assign op_count = op_count_r;
`else
    // No counter in this build; results are handed off without being tallied.
`endif

endmodule

// File: doc/cordic_sched.md
# cordic_sched

Round-robin scheduler and sequencer for one shared `cordic_data` datapath. It accepts rotation requests from up to `NUM_REQ` clients over valid/ready handshakes and grants one request at a time. For the granted request it drives `load_regs`, `add`, `sub` and `iter` until the datapath reports `reached_target`. It then returns the captured `x`/`y` magnitudes, tagged with the requester ID, on a valid/ready result port. The block sits between the client subsystems and a single `cordic_data` instance, which it owns exclusively.

## Interface
Clocking and reset:
- One clock, `clk`; all logic on its rising edge.
- Reset is asynchronous and active-high, on port `reset`.

Parameters:
- `BIT_WIDTH`, default 16: angle and magnitude width; must match the datapath.
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `ID_WIDTH`, default 2: requester ID width; must equal `$clog2(NUM_REQ)`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester request valid.
- `req_target`, in, `NUM_REQ*BIT_WIDTH`: flattened target angles; requester k uses slice `[k*BIT_WIDTH +: BIT_WIDTH]`.
- `req_ready`, out, `NUM_REQ`: one-hot grant; all zero when busy.
- `load_regs`, out, 1: datapath initialise strobe.
- `add`, out, 1: datapath counter-clockwise step strobe.
- `sub`, out, 1: datapath clockwise step strobe.
- `iter`, out, 1: datapath index increment strobe.
- `target_out`, out, `BIT_WIDTH`: target angle presented to the datapath.
- `dp_x`, in, `BIT_WIDTH`: datapath x magnitude.
- `dp_y`, in, `BIT_WIDTH`: datapath y magnitude.
- `reached_target`, in, 1: datapath final-index flag.
- `dir`, in, 1: datapath direction flag.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: result consumer ready.
- `out_x`, out, `BIT_WIDTH`: captured x magnitude.
- `out_y`, out, `BIT_WIDTH`: captured y magnitude.
- `out_id`, out, `ID_WIDTH`: ID of the requester that owns the result.

## Operation
State machine `IDLE → LOAD → ROTATE → DONE → IDLE`:
- **IDLE**
  - The round-robin arbiter selects a requester among asserted `req_valid` bits.
  - The search starts at `ptr`; `ptr` resets to 0.
  - `req_ready` is one-hot on the winner.
  - On the handshake: the target is latched into `tgt_q`, the ID into `id_q`, `ptr` becomes winner+1 (mod `NUM_REQ`), and the FSM moves to LOAD.
  - With no valid requests, stay in IDLE.
- **LOAD**
  - `load_regs`=1; `target_out`=`tgt_q`.
  - Always moves to ROTATE.
- **ROTATE**
  - If `reached_target`=0: `add`=`dir`, `sub`=`!dir`, `iter`=1.
  - If `reached_target`=1: all strobes are 0, `dp_x`/`dp_y` are captured into `out_x`/`out_y`, and the FSM moves to DONE.
- **DONE**
  - `out_valid`=1.
  - On `out_valid & out_ready`, move to IDLE.
  - `out_x`, `out_y` and `out_id` are stable while waiting.

Rules:
- `add` and `sub` are never asserted together.
- Outside LOAD and ROTATE, all strobes are 0.
- `target_out` continuously equals `tgt_q`.
- `req_ready` is 0 in every state except IDLE.
- A requester dropping `req_valid` before it is granted is legal; there is no obligation to hold.
- A request is consumed only by a `req_valid & req_ready` handshake.

## Timing
- Handshake in cycle 0; LOAD in cycle 1.
- Steps in cycles 2..`BIT_WIDTH` (`BIT_WIDTH`−1 steps); the capture check in cycle `BIT_WIDTH`+1.
- `out_valid` rises in cycle `BIT_WIDTH`+2. With `BIT_WIDTH`=16, latency is 18 cycles.
- With `out_ready` held at 1, the next grant is possible in cycle `BIT_WIDTH`+3, so throughput is one operation per `BIT_WIDTH`+3 cycles.
- Reset values: FSM=IDLE, `ptr`=0, `req_ready`=0 only while `req_valid`=0 (it is combinational from IDLE and `req_valid`), all strobes 0, `out_valid`=0, `out_x`/`out_y`/`target_out`/`out_id`=0.
- Reset mid-operation aborts immediately; no result is produced. Datapath state is not cleared, because the next LOAD reinitialises it.
- If `reached_target` is already 1 on entering ROTATE (corrupt datapath), capture immediately; no strobes are issued.

## Configuration
- `CORDIC_SCHED_OPCOUNT_EN` defined:
  - Adds output `op_count` [31:0].
  - It increments on each `out_valid & out_ready` handshake, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `cordic_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, LOAD, ROTATE, DONE), 2 bits;
  - localparam `OPCOUNT_WIDTH` = 32.
- Sub-module `cordic_rr_arbiter` (parameter `NUM_REQ`):
  - inputs: `req`, `ptr`, `enable`;
  - outputs: one-hot `grant` and binary `grant_id`;
  - purely combinational.
- `ptr`, `tgt_q`, `id_q` and the output registers live in `cordic_sched`.

## Test plan
All scenarios use `BIT_WIDTH`=16, `NUM_REQ`=4, and a model datapath.
- **Single request:** requester 2 requests target 0x2000 with `out_ready`=1 → `load_regs` pulse in cycle 1; 15 `iter` pulses; `out_valid` in cycle 18 with `out_id`=2; no `add` and `sub` overlap.
- **Round-robin:** all 4 `req_valid` held high → grant order 0,1,2,3,0; `req_ready` is zero during every busy cycle.
- **Backpressure:** `out_ready`=0 for 10 cycles after `out_valid` → `out_x`/`out_y`/`out_id` stable and `req_ready`=0 until the handshake; IDLE on the next cycle.
- **Direction tracking:** a model `dir` pattern of alternating 1,0 → `add` and `sub` alternate each ROTATE cycle, matching `dir` in the same cycle.
- **Mid-operation reset:** `reset` asserted in cycle 7 of an operation → all outputs 0 asynchronously; after release, requester 0 is granted first (`ptr`=0).
- **Op counter:** with `CORDIC_SCHED_OPCOUNT_EN` defined, 3 completed operations → `op_count`=3.
